// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax engine scheduler.
package softmax_pkg;

    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/softmax_sched_rr_arbiter.sv
// Combinational round-robin picker: the nearest requester after last_grant (with wrap) wins.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant
);

    int          idx;
    logic [N-1:0] cand;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = 0;
        cand  = '0;
        // Walk from the farthest candidate to the nearest so the nearest one overwrites.
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= N) idx = idx - N;
            cand = N'(1) << idx;
            if ((req & cand) != '0) grant = cand;
        end
    end

endmodule

// File: rtl/softmax_sched.sv
// Shares one softmax engine among N_REQ requesters: round-robin grant, issue, wait with timeout, respond.
module softmax_sched
    import softmax_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ack,
    output logic                       eng_start,
    output logic [DATA_W-1:0]          eng_data,
    input  logic                       eng_busy,
    input  logic                       eng_done,
    input  logic [DATA_W-1:0]          eng_result,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [DATA_W-1:0]          resp_data,
    output logic                       err_timeout,
    input  logic                       err_clr
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    sched_state_t      state, state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  grant_q;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  wait_cnt;
    logic              take;
    logic              timeout_hit;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign take        = (state == IDLE) && (|req) && !eng_busy;
    assign timeout_hit = (state == WAIT) && !eng_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        grant_id = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (eng_done)         state_next = RESP;
                else if (timeout_hit) state_next = IDLE;
            end
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= ID_W'(N_REQ - 1);
            grant_q     <= '0;
            resp_id     <= '0;
            eng_data    <= '0;
            resp_data   <= '0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (take) begin
                grant_q    <= grant;
                resp_id    <= grant_id;
                last_grant <= grant_id;
                eng_data   <= sel_data;
            end
            if (state == ISSUE)
                wait_cnt <= '0;
            else if ((state == WAIT) && !eng_done && !timeout_hit)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if ((state == WAIT) && eng_done)
                resp_data <= eng_result;
            // A timeout in the same cycle as a clear leaves the flag set.
            if (timeout_hit)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

    assign eng_start  = (state == ISSUE);
    assign req_ack    = (state == ISSUE) ? grant_q : '0;
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_softmax_sched.sv
// Directed bench for softmax_sched: latency, round-robin order, backpressure, timeout, busy gating, reset.
module tb_softmax_sched;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic                    eng_start;
    logic [DATA_W-1:0]       eng_data;
    logic                    eng_busy;
    logic                    eng_done;
    logic [DATA_W-1:0]       eng_result;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [1:0]              resp_id;
    logic [DATA_W-1:0]       resp_data;
    logic                    err_timeout;
    logic                    err_clr;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] dvec [N_REQ];
    localparam logic [DATA_W-1:0] RBASE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    always #5 clk = ~clk;

    softmax_sched #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .eng_start   (eng_start),
        .eng_data    (eng_data),
        .eng_busy    (eng_busy),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts just after a rising edge; ends at the falling edge of the ISSUE cycle.
    task automatic wait_start(output int lat);
        int k;
        k = 0;
        @(negedge clk);
        while (!eng_start && k < 12) begin
            step();
            @(negedge clk);
            k++;
        end
        lat = k;
        check("eng_start_seen", 128'(eng_start), 128'(1));
    endtask

    // One full transaction with a 3-cycle engine; bp = cycles of resp_ready=0 in RESP.
    task automatic txn(input int exp_id, input logic [DATA_W-1:0] res,
                       input logic [N_REQ-1:0] req_after, input int bp, output int lat);
        logic [N_REQ-1:0] exp_ack;
        exp_ack    = N_REQ'(1) << exp_id;
        resp_ready = (bp == 0);
        wait_start(lat);
        check("req_ack", 128'(req_ack), 128'(exp_ack));
        check("eng_data", eng_data, dvec[exp_id]);
        step();
        req = req_after;
        @(negedge clk);
        check("no_resp_in_wait", 128'({resp_valid, eng_start}), 128'(0));
        step();
        step();
        eng_done   = 1'b1;
        eng_result = res;
        step();
        eng_done   = 1'b0;
        eng_result = '0;
        @(negedge clk);
        check("resp_valid", 128'(resp_valid), 128'(1));
        check("resp_id", 128'(resp_id), 128'(exp_id));
        check("resp_data", resp_data, res);
        for (int i = 1; i <= bp; i++) begin
            step();
            if (i == bp) resp_ready = 1'b1;
            @(negedge clk);
            check("bp_hold_valid_nostart", 128'({resp_valid, eng_start}), 128'(2'b10));
            check("bp_hold_data", resp_data, res);
            check("bp_hold_id", 128'(resp_id), 128'(exp_id));
        end
        step();
        @(negedge clk);
        check("idle_after_resp", 128'(resp_valid), 128'(0));
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int lat;
        rst_n      = 1'b1;
        req        = '0;
        eng_busy   = 1'b0;
        eng_done   = 1'b0;
        eng_result = '0;
        resp_ready = 1'b1;
        err_clr    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            dvec[i] = {4{32'hC0DE_0000 | 32'(i)}};
            req_data[i*DATA_W +: DATA_W] = dvec[i];
        end
        #1 rst_n = 1'b0;
        #1;
        check("rst_ctrl", 128'({req_ack, eng_start, resp_valid, err_timeout, resp_id}), 128'(0));
        check("rst_resp_data", resp_data, 128'(0));
        check("rst_eng_data", eng_data, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single request: ack/start one cycle after req rises, response four cycles later.
        req = 4'b0001;
        txn(0, RBASE, 4'b0000, 0, lat);
        check("t1_latency", 128'(lat), 128'(1));

        // All requesting from reset: grant order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < 5; j++)
            txn(j % 4, RBASE + 128'(j + 1), (j == 4) ? 4'b0000 : 4'b1111, 0, lat);

        // Backpressure: ready low for 10 RESP cycles.
        req = 4'b0100;
        txn(2, RBASE + 128'(16), 4'b0000, 10, lat);

        // Timeout: engine never finishes; err_clr coincides with the timeout cycle.
        req = 4'b1000;
        wait_start(lat);
        check("to_req_ack", 128'(req_ack), 128'(4'b1000));
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            if (i == 1) req = 4'b0000;
            if (i == TIMEOUT) err_clr = 1'b1;
            @(negedge clk);
            check("to_wait_quiet", 128'({resp_valid, err_timeout}), 128'(0));
        end
        step();
        err_clr = 1'b0;
        @(negedge clk);
        check("to_err_set", 128'(err_timeout), 128'(1));
        check("to_no_resp", 128'({resp_valid, eng_start}), 128'(0));
        step();
        req = 4'b0001;
        txn(0, RBASE + 128'(32), 4'b0000, 0, lat);
        check("to_err_sticky", 128'(err_timeout), 128'(1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        check("to_err_cleared", 128'(err_timeout), 128'(0));
        step();

        // Busy gating: no grant while busy, grant the cycle after busy falls.
        eng_busy = 1'b1;
        req      = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_no_grant", 128'({eng_start, req_ack}), 128'(0));
            step();
        end
        eng_busy = 1'b0;
        txn(1, RBASE + 128'(48), 4'b0000, 0, lat);
        check("busy_latency", 128'(lat), 128'(1));

        // Reset while waiting on the engine; a late eng_done must be ignored.
        req = 4'b0100;
        wait_start(lat);
        check("rw_req_ack", 128'(req_ack), 128'(4'b0100));
        step();
        req = 4'b0000;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rw_ctrl_zero", 128'({req_ack, eng_start, resp_valid, err_timeout, resp_id}), 128'(0));
        check("rw_resp_data_zero", resp_data, 128'(0));
        check("rw_eng_data_zero", eng_data, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        eng_done   = 1'b1;
        eng_result = RBASE + 128'(64);
        step();
        eng_done   = 1'b0;
        eng_result = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rw_done_ignored", 128'({resp_valid, eng_start}), 128'(0));
            check("rw_resp_data_held", resp_data, 128'(0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
